hazard_sequencer: RTL and testbench
===================================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter OP_LOAD, default 6'b010100, load opcode.
REQ-002 Parameter OP_HLT, default 6'b010001, halt opcode.
REQ-003 Parameter OP_MUL, default 6'b011000, multi-cycle multiply/divide opcode.
REQ-004 Parameter JMP_PREFIX, default 4'b0111, jump class when op_id[5:2]==JMP_PREFIX.
REQ-005 Parameter MD_MAX, default 32, maximum cycles waited for md_done.
REQ-006 The block SHALL use one clock, clk; reset is asynchronous and active-low.
REQ-007 Port list:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_id  in  6  opcode of the instruction in ID.
- rs_id, rt_id  in  3 each  source registers of the instruction in ID.
- ex_load  in  1  instruction in EX is a load.
- ex_rd  in  3  destination register of the instruction in EX.
- md_done  in  1  multiply/divide unit finished.
- resume  in  1  release from halt.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID register cleared to NOP.
- idex_bubble  out  1  NOP injected into ID/EX.
- md_start  out  1  one-cycle start pulse to the MD unit.
- stall  out  1  equals ~pc_en.
- halted  out  1  the FSM is in HALT.
- md_error  out  1  sticky MD timeout flag.

Function
REQ-008 The FSM SHALL have states RUN, LSTALL, JFLUSH, MDWAIT and HALT; outputs are combinational from state and inputs, and state is registered.
REQ-009 Defaults, in any state unless overridden: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, md_start=0.
REQ-010 RUN and LSTALL decode, in priority order HLT > jump > MUL > load-use; the first match wins.
REQ-011 HLT (op_id==OP_HLT): pc_en=0, ifid_en=0, idex_bubble=1; next state HALT.
REQ-012 Jump (op_id[5:2]==JMP_PREFIX): pc_en=1, ifid_flush=1; the jump passes to EX; next state JFLUSH.
REQ-013 JFLUSH: ifid_flush=1, pc_en=1, with no decode; next state RUN, giving exactly 2 flushed fetch slots per jump.
REQ-014 MUL (op_id==OP_MUL): md_start=1, pc_en=0, ifid_en=0, idex_bubble=1; clear the counter; next state MDWAIT.
REQ-015 MDWAIT, md_done=0: pc_en=0, ifid_en=0, idex_bubble=1; the counter increments.
REQ-016 MDWAIT, md_done=1: default outputs, so the MUL advances to EX; next state RUN.
REQ-017 MDWAIT timeout: when the counter reaches MD_MAX-1 with md_done=0, release as in REQ-016, set md_error=1, and go to RUN.
REQ-018 md_error SHALL stay set until reset; md_done outside MDWAIT is ignored.
REQ-019 Load-use, RUN only: ex_load=1 and ex_rd!=0 and (ex_rd==rs_id or ex_rd==rt_id) gives pc_en=0, ifid_en=0, idex_bubble=1; next state LSTALL.
REQ-020 LSTALL: load-use check masked and other decode as RUN; with no match, defaults and next state RUN; exactly 1 bubble per load-use.
REQ-021 HALT: pc_en=0, ifid_en=0, idex_bubble=1, halted=1.
REQ-022 HALT with resume=1: pc_en=1, ifid_flush=1 (the HLT is discarded); next state RUN.
REQ-023 resume outside HALT is ignored.
REQ-024 The MD counter SHALL be $clog2(MD_MAX)+1 bits wide and saturate, never wrapping.
REQ-025 Register 0 never causes a load-use stall.

Reset
REQ-026 While reset=0, asynchronously: state=RUN, counter=0, md_error=0.
REQ-027 While reset=0, outputs are forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, md_start=0, halted=0, stall=1.
REQ-028 Reset asserted mid-MDWAIT, mid-JFLUSH or mid-HALT SHALL abort to RUN, with no md_start pulse on release.
REQ-029 The first clk edge after reset rises SHALL evaluate RUN decode.

Verification
REQ-030 Load-use: ex_load=1, ex_rd=3, op_id=ADD with rs_id=3 -> 1 cycle of pc_en=0/idex_bubble=1, then normal flow; the same case with ex_rd=0 -> no stall.
REQ-031 Jump: op_id=6'b011100 -> ifid_flush=1 for 2 consecutive cycles, pc_en=1 throughout, then RUN.
REQ-032 MUL: op_id=OP_MUL, md_done after 5 cycles -> md_start high for 1 cycle, stall high for 6 cycles, md_error=0.
REQ-033 MD timeout: md_done never asserted, MD_MAX=32 -> release after 32 stall cycles, md_error=1 and still 1 after a later MUL.
REQ-034 Halt: op_id=OP_HLT, resume pulsed 10 cycles later -> halted=1 for 10 cycles, then one ifid_flush=1 with pc_en=1.
REQ-035 Priority and reset: HLT opcode with a load-use match -> HALT entered with no LSTALL; reset=0 mid-MDWAIT -> immediate RUN and forced outputs, with md_error cleared.

Source files
------------

// File: rtl/hazard_sequencer_if.sv
// Pipeline hazard control bundle between the decode stage and the hazard sequencer.
//   Decode-side inputs : op_id, rs_id, rt_id, ex_load, ex_rd, md_done, resume
//   Control outputs    : pc_en, ifid_en, ifid_flush, idex_bubble, md_start,
//                        stall, halted, md_error
//   master modport : the pipeline side (drives decode info, observes controls)
//   slave modport  : the sequencer side
interface hazard_sequencer_if;
   logic [5:0] op_id;
   logic [2:0] rs_id;
   logic [2:0] rt_id;
   logic       ex_load;
   logic [2:0] ex_rd;
   logic       md_done;
   logic       resume;
   logic       pc_en;
   logic       ifid_en;
   logic       ifid_flush;
   logic       idex_bubble;
   logic       md_start;
   logic       stall;
   logic       halted;
   logic       md_error;

   modport master (
      output op_id, rs_id, rt_id, ex_load, ex_rd, md_done, resume,
      input  pc_en, ifid_en, ifid_flush, idex_bubble, md_start, stall, halted, md_error
   );

   modport slave (
      input  op_id, rs_id, rt_id, ex_load, ex_rd, md_done, resume,
      output pc_en, ifid_en, ifid_flush, idex_bubble, md_start, stall, halted, md_error
   );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard sequencer for a 5-stage pipeline: handles halt, jump flush,
// multi-cycle multiply/divide wait (with timeout) and load-use stalls.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : hazard_sequencer_if.slave (decode info in, pipeline controls out)
module hazard_sequencer #(
   parameter logic [5:0] OP_LOAD    = 6'b010100,
   parameter logic [5:0] OP_HLT     = 6'b010001,
   parameter logic [5:0] OP_MUL     = 6'b011000,
   parameter logic [3:0] JMP_PREFIX = 4'b0111,
   parameter int         MD_MAX     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   hazard_sequencer_if.slave     bus
);
   localparam int CW = $clog2(MD_MAX) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MD_MAX - 1);
   localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

   typedef enum logic [2:0] {
      S_RUN    = 3'd0,
      S_LSTALL = 3'd1,
      S_JFLUSH = 3'd2,
      S_MDWAIT = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [CW-1:0] r_cnt;
   logic          r_md_error;

   logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_bubble, w_md_start, w_halted;
   logic w_cnt_clr, w_cnt_inc, w_set_err;
   logic w_is_hlt, w_is_jmp, w_is_mul, w_load_use;

   // OP_LOAD identifies loads in ID; the EX-side load flag arrives decoded,
   // so the parameter only documents the encoding.
   logic w_unused_load;
   assign w_unused_load = (OP_LOAD == 6'd0);

   assign w_is_hlt   = (bus.op_id == OP_HLT);
   assign w_is_jmp   = (bus.op_id[5:2] == JMP_PREFIX);
   assign w_is_mul   = (bus.op_id == OP_MUL);
   // Register 0 is hardwired zero, so a load targeting it creates no hazard.
   assign w_load_use = bus.ex_load && (bus.ex_rd != 3'd0) &&
                       ((bus.ex_rd == bus.rs_id) || (bus.ex_rd == bus.rt_id));

   always_comb begin
      w_pc_en       = 1'b1;
      w_ifid_en     = 1'b1;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      w_md_start    = 1'b0;
      w_halted      = 1'b0;
      w_cnt_clr     = 1'b0;
      w_cnt_inc     = 1'b0;
      w_set_err     = 1'b0;
      w_next_state  = S_RUN;

      case (r_state)
         S_RUN, S_LSTALL: begin
            if (w_is_hlt) begin
               w_pc_en       = 1'b0;
               w_ifid_en     = 1'b0;
               w_idex_bubble = 1'b1;
               w_next_state  = S_HALT;
            end else if (w_is_jmp) begin
               w_ifid_flush  = 1'b1;
               w_next_state  = S_JFLUSH;
            end else if (w_is_mul) begin
               w_md_start    = 1'b1;
               w_pc_en       = 1'b0;
               w_ifid_en     = 1'b0;
               w_idex_bubble = 1'b1;
               w_cnt_clr     = 1'b1;
               w_next_state  = S_MDWAIT;
            end else if ((r_state == S_RUN) && w_load_use) begin
               // Masked in LSTALL so each load-use costs exactly one bubble.
               w_pc_en       = 1'b0;
               w_ifid_en     = 1'b0;
               w_idex_bubble = 1'b1;
               w_next_state  = S_LSTALL;
            end
         end
         S_JFLUSH: begin
            // Second wrong-path fetch slot after a jump.
            w_ifid_flush = 1'b1;
         end
         S_MDWAIT: begin
            if (bus.md_done) begin
               w_next_state = S_RUN;
            end else if (r_cnt == CNT_LAST) begin
               w_set_err    = 1'b1;
               w_next_state = S_RUN;
            end else begin
               w_pc_en       = 1'b0;
               w_ifid_en     = 1'b0;
               w_idex_bubble = 1'b1;
               w_cnt_inc     = 1'b1;
               w_next_state  = S_MDWAIT;
            end
         end
         S_HALT: begin
            w_halted = 1'b1;
            if (bus.resume) begin
               // The HLT still sitting in IF/ID is discarded.
               w_ifid_flush = 1'b1;
               w_next_state = S_RUN;
            end else begin
               w_pc_en       = 1'b0;
               w_ifid_en     = 1'b0;
               w_idex_bubble = 1'b1;
               w_next_state  = S_HALT;
            end
         end
         default: w_next_state = S_RUN;
      endcase

      // Reset holds the pipeline frozen with a NOP in flight.
      if (!reset) begin
         w_pc_en       = 1'b0;
         w_ifid_en     = 1'b0;
         w_ifid_flush  = 1'b1;
         w_idex_bubble = 1'b1;
         w_md_start    = 1'b0;
         w_halted      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_RUN;
         r_cnt      <= '0;
         r_md_error <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_cnt_clr)
            r_cnt <= '0;
         else if (w_cnt_inc && (r_cnt != CNT_SAT))
            r_cnt <= r_cnt + 1'b1;
         if (w_set_err)
            r_md_error <= 1'b1;
      end
   end

   assign bus.pc_en       = w_pc_en;
   assign bus.ifid_en     = w_ifid_en;
   assign bus.ifid_flush  = w_ifid_flush;
   assign bus.idex_bubble = w_idex_bubble;
   assign bus.md_start    = w_md_start;
   assign bus.stall       = ~w_pc_en;
   assign bus.halted      = w_halted;
   assign bus.md_error    = r_md_error;
endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;
   localparam logic [5:0] OP_HLT = 6'b010001;
   localparam logic [5:0] OP_MUL = 6'b011000;
   localparam logic [5:0] OP_JMP = 6'b011100;
   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam int         MD_MAX = 32;

   logic clk;
   logic reset;
   hazard_sequencer_if bus_if();

   hazard_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected control word: {pc_en, ifid_en, ifid_flush, idex_bubble,
   //                         md_start, stall, halted, md_error}
   logic [7:0] exp_q[$];
   int vectors;
   int miscompares;
   bit stim_done;

   // Reference model: pipeline bookkeeping expressed as pending work counts.
   bit m_halted;      // CPU parked on a HLT
   int m_flush_left;  // wrong-path fetch slots still to be squashed
   bit m_md_busy;     // waiting on the multiply/divide unit
   int m_md_stalls;   // stall cycles charged to the current MUL so far
   bit m_lu_masked;   // a load-use bubble was just inserted
   bit m_err;

   function automatic logic [7:0] pack(bit pc, bit en, bit fl, bit bub, bit ms, bit hl, bit er);
      return {pc, en, fl, bub, ms, ~pc, hl, er};
   endfunction

   task automatic model_step(output logic [7:0] e);
      bit lu;
      bit next_mask;
      if (!reset) begin
         m_halted = 0; m_flush_left = 0; m_md_busy = 0; m_md_stalls = 0;
         m_lu_masked = 0; m_err = 0;
         e = pack(0, 0, 1, 1, 0, 0, 0);
         return;
      end
      next_mask = 0;
      if (m_halted) begin
         if (bus_if.resume) begin
            e = pack(1, 1, 1, 0, 0, 1, m_err);
            m_halted = 0;
         end else
            e = pack(0, 0, 0, 1, 0, 1, m_err);
      end else if (m_flush_left > 0) begin
         e = pack(1, 1, 1, 0, 0, 0, m_err);
         m_flush_left--;
      end else if (m_md_busy) begin
         if (bus_if.md_done) begin
            e = pack(1, 1, 0, 0, 0, 0, m_err);
            m_md_busy = 0;
         end else if (m_md_stalls >= MD_MAX) begin
            e = pack(1, 1, 0, 0, 0, 0, m_err);
            m_md_busy = 0;
            m_err = 1;
         end else begin
            e = pack(0, 0, 0, 1, 0, 0, m_err);
            m_md_stalls++;
         end
      end else begin
         lu = bus_if.ex_load && bus_if.ex_rd != 0 &&
              (bus_if.ex_rd == bus_if.rs_id || bus_if.ex_rd == bus_if.rt_id);
         if (bus_if.op_id == OP_HLT) begin
            e = pack(0, 0, 0, 1, 0, 0, m_err);
            m_halted = 1;
         end else if (bus_if.op_id[5:2] == 4'b0111) begin
            e = pack(1, 1, 1, 0, 0, 0, m_err);
            m_flush_left = 1;
         end else if (bus_if.op_id == OP_MUL) begin
            e = pack(0, 0, 0, 1, 1, 0, m_err);
            m_md_busy = 1;
            m_md_stalls = 1;
         end else if (lu && !m_lu_masked) begin
            e = pack(0, 0, 0, 1, 0, 0, m_err);
            next_mask = 1;
         end else
            e = pack(1, 1, 0, 0, 0, 0, m_err);
      end
      m_lu_masked = next_mask;
   endtask

   // Apply one cycle of stimulus and queue the expected response.
   task automatic drive(input logic [5:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input bit exl, input logic [2:0] exrd, input bit mdd,
                        input bit res, input bit rstn);
      logic [7:0] e;
      @(negedge clk);
      bus_if.op_id = op; bus_if.rs_id = rs; bus_if.rt_id = rt;
      bus_if.ex_load = exl; bus_if.ex_rd = exrd;
      bus_if.md_done = mdd; bus_if.resume = res;
      reset = rstn;
      #1;
      model_step(e);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(OP_ADD, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
   endtask

   // Monitor: the control word is valid every cycle; compare whenever one is expected.
   initial begin : monitor
      logic [7:0] act, e;
      while (!stim_done) begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {bus_if.pc_en, bus_if.ifid_en, bus_if.ifid_flush, bus_if.idex_bubble,
                   bus_if.md_start, bus_if.stall, bus_if.halted, bus_if.md_error};
            vectors++;
            if (act !== e) begin
               miscompares++;
               $display("FAIL ctrl_word t=%0t op=%b actual pc/en/fl/bub/ms/st/hl/er=%b required=%b",
                        $time, bus_if.op_id, act, e);
            end else
               $display("ok   t=%0t op=%b ctrl=%b", $time, bus_if.op_id, act);
         end
      end
   end

   initial begin : stimulus
      vectors = 0; miscompares = 0; stim_done = 0;
      reset = 1'b0;
      bus_if.op_id = OP_ADD; bus_if.rs_id = 0; bus_if.rt_id = 0;
      bus_if.ex_load = 0; bus_if.ex_rd = 0; bus_if.md_done = 0; bus_if.resume = 0;
      m_halted = 0; m_flush_left = 0; m_md_busy = 0; m_md_stalls = 0;
      m_lu_masked = 0; m_err = 0;

      // Reset state
      drive(OP_ADD, 3'd1, 3'd2, 0, 3'd0, 0, 0, 0);
      drive(OP_MUL, 3'd1, 3'd2, 0, 3'd0, 0, 0, 0);
      idle(2);
      // Load-use: one bubble, then the same instruction flows
      drive(OP_ADD, 3'd3, 3'd5, 1, 3'd3, 0, 0, 1);
      drive(OP_ADD, 3'd3, 3'd5, 1, 3'd3, 0, 0, 1);
      idle(1);
      // Load-use via rt
      drive(OP_ADD, 3'd6, 3'd4, 1, 3'd4, 0, 0, 1);
      drive(OP_ADD, 3'd6, 3'd4, 1, 3'd4, 0, 0, 1);
      // Register 0 never stalls
      drive(OP_ADD, 3'd0, 3'd5, 1, 3'd0, 0, 0, 1);
      idle(1);
      // Jump: two flushed slots
      drive(OP_JMP, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
      idle(3);
      // MUL with md_done after 5 wait cycles
      drive(OP_MUL, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
      for (int i = 0; i < 5; i++) drive(OP_ADD, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
      drive(OP_ADD, 3'd1, 3'd2, 0, 3'd0, 1, 0, 1);
      idle(2);
      // md_done outside MDWAIT and resume outside HALT are ignored
      drive(OP_ADD, 3'd1, 3'd2, 0, 3'd0, 1, 1, 1);
      // MD timeout, sticky error survives a later MUL
      drive(OP_MUL, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
      for (int i = 0; i < 36; i++) drive(OP_ADD, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
      drive(OP_MUL, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
      drive(OP_ADD, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
      drive(OP_ADD, 3'd1, 3'd2, 0, 3'd0, 1, 0, 1);
      idle(1);
      // Halt with resume 10 cycles later
      drive(OP_HLT, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
      for (int i = 0; i < 9; i++) drive(OP_HLT, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
      drive(OP_HLT, 3'd1, 3'd2, 0, 3'd0, 0, 1, 1);
      idle(2);
      // HLT beats a load-use match
      drive(OP_HLT, 3'd2, 3'd2, 1, 3'd2, 0, 0, 1);
      drive(OP_ADD, 3'd2, 3'd2, 1, 3'd2, 0, 1, 1);
      idle(1);
      // Reset mid-MDWAIT (after an error) aborts to RUN and clears md_error
      drive(OP_MUL, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
      idle(3);
      drive(OP_ADD, 3'd1, 3'd2, 0, 3'd0, 0, 0, 0);
      idle(3);
      // Reset mid-JFLUSH and mid-HALT
      drive(OP_JMP, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
      drive(OP_ADD, 3'd1, 3'd2, 0, 3'd0, 0, 0, 0);
      idle(1);
      drive(OP_HLT, 3'd1, 3'd2, 0, 3'd0, 0, 0, 1);
      drive(OP_ADD, 3'd1, 3'd2, 0, 3'd0, 0, 0, 0);
      idle(2);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [5:0] op;
         int sel;
         sel = $urandom_range(0, 11);
         case (sel)
            0:       op = OP_HLT;
            1:       op = {4'b0111, 2'($urandom_range(0, 3))};
            2:       op = OP_MUL;
            3:       op = 6'b010100;
            default: op = 6'($urandom_range(0, 63));
         endcase
         drive(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
               $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 199) != 0);
      end

      repeat (2) @(negedge clk);
      #3;
      stim_done = 1;
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "simulation time limit");
   end
endmodule
